// File: rtl/v_pkg.sv
// Shared types for the list-update notify path: product ids, level-0 key/size and
// the notify beat carried towards the egress consumer.
package v_pkg;

  localparam int unsigned PRODUCTS_N     = 16;
  localparam int unsigned ID_W           = $clog2(PRODUCTS_N);
  localparam int unsigned KEY_W          = 32;
  localparam int unsigned SIZE_W         = 16;
  localparam int unsigned COALESCE_CNT_W = 16;

  typedef logic [ID_W-1:0]   id_t;
  typedef logic [KEY_W-1:0]  key_t;
  typedef logic [SIZE_W-1:0] size_t;

  typedef struct packed {
    id_t   prod_id;
    key_t  key;
    size_t size;
  } ntf_t;

endpackage

// File: rtl/v_notify_coalesce_idq.sv
// Circular FIFO of product ids awaiting egress; depth equals the product count,
// so with one pending slot per product it can never legitimately overflow.
module v_notify_coalesce_idq
  import v_pkg::*;
#(
  parameter int unsigned DEPTH = PRODUCTS_N
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  id_t                      push_id,
  input  logic                     pop,
  output id_t                      head_id,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  id_t              mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty   = (count == '0);
    full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    do_pop  = pop & ~empty;
    head_id = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/v_notify_coalesce.sv
// Coalesces level-0 notify updates per product and replays the latest key/size
// to a valid/ready egress consumer in first-pending order.
module v_notify_coalesce
  import v_pkg::*;
#(
  parameter int unsigned PROD_N = PRODUCTS_N,
  parameter int unsigned CNT_W  = COALESCE_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_lv0_vld,
  input  id_t                       i_lv0_prod_id,
  input  key_t                      i_lv0_key,
  input  size_t                     i_lv0_size,
  output logic                      o_ntf_vld_r,
  output id_t                       o_ntf_prod_id_r,
  output key_t                      o_ntf_key_r,
  output size_t                     o_ntf_size_r,
  input  logic                      i_ntf_rdy,
  output logic [CNT_W-1:0]          o_coalesce_cnt_r,
  output logic [$clog2(PROD_N):0]   o_pend_cnt_r
);

  logic              slot_free, q_empty, q_full;
  logic              pop, bypass, collide, ing, push, coal_inc;
  id_t               head_id;
  logic [PROD_N-1:0] pend_r, pend_nxt;
  key_t              tbl_key  [PROD_N];
  size_t             tbl_size [PROD_N];
  ntf_t              ntf_r;

  assign o_ntf_prod_id_r = ntf_r.prod_id;
  assign o_ntf_key_r     = ntf_r.key;
  assign o_ntf_size_r    = ntf_r.size;

  // A pop whose head matches the incoming id takes the fresh value directly;
  // the table copy it would have read is stale by then.
  always_comb begin
    slot_free = ~o_ntf_vld_r | i_ntf_rdy;
    pop       = slot_free & ~q_empty;
    bypass    = slot_free & q_empty & i_lv0_vld;
    collide   = pop & i_lv0_vld & (i_lv0_prod_id == head_id);
    ing       = i_lv0_vld & ~bypass & ~collide;
    push      = ing & ~pend_r[i_lv0_prod_id];
    coal_inc  = collide | (ing & pend_r[i_lv0_prod_id]);

    pend_nxt = pend_r;
    if (pop)  pend_nxt[head_id]       = 1'b0;
    if (push) pend_nxt[i_lv0_prod_id] = 1'b1;
  end

  v_notify_coalesce_idq #(.DEPTH(PROD_N)) u_idq (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (i_lv0_prod_id),
    .pop     (pop),
    .head_id (head_id),
    .empty   (q_empty),
    .full    (q_full),
    .count   (o_pend_cnt_r)
  );

  always_ff @(posedge clk) begin
    if (i_lv0_vld & ~bypass) begin
      tbl_key[i_lv0_prod_id]  <= i_lv0_key;
      tbl_size[i_lv0_prod_id] <= i_lv0_size;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ntf_vld_r <= 1'b0;
      ntf_r       <= '0;
    end else if (pop) begin
      o_ntf_vld_r <= 1'b1;
      ntf_r       <= collide ? '{i_lv0_prod_id, i_lv0_key, i_lv0_size}
                             : '{head_id, tbl_key[head_id], tbl_size[head_id]};
    end else if (bypass) begin
      o_ntf_vld_r <= 1'b1;
      ntf_r       <= '{i_lv0_prod_id, i_lv0_key, i_lv0_size};
    end else if (slot_free) begin
      o_ntf_vld_r <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r           <= '0;
      o_coalesce_cnt_r <= '0;
    end else begin
      pend_r <= pend_nxt;
      if (coal_inc && (o_coalesce_cnt_r != '1))
        o_coalesce_cnt_r <= o_coalesce_cnt_r + 1'b1;
    end
  end

  a_push_not_full : assert property (@(posedge clk) disable iff (rst) push |-> !q_full);

endmodule

// File: tb/tb_v_notify_coalesce.sv
// Bench for v_notify_coalesce: directed vector table, hand-written corner
// sequences and a random run against a queue-based reference model.
module tb_v_notify_coalesce;
  import v_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_lv0_vld = 1'b0;
  id_t         i_lv0_prod_id = '0;
  key_t        i_lv0_key = '0;
  size_t       i_lv0_size = '0;
  logic        i_ntf_rdy = 1'b0;
  logic        o_ntf_vld_r;
  id_t         o_ntf_prod_id_r;
  key_t        o_ntf_key_r;
  size_t       o_ntf_size_r;
  logic [15:0] o_coalesce_cnt_r;
  logic [4:0]  o_pend_cnt_r;

  int n_chk  = 0;
  int n_pass = 0;

  v_notify_coalesce #(.PROD_N(16), .CNT_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_lv0_vld        (i_lv0_vld),
    .i_lv0_prod_id    (i_lv0_prod_id),
    .i_lv0_key        (i_lv0_key),
    .i_lv0_size       (i_lv0_size),
    .o_ntf_vld_r      (o_ntf_vld_r),
    .o_ntf_prod_id_r  (o_ntf_prod_id_r),
    .o_ntf_key_r      (o_ntf_key_r),
    .o_ntf_size_r     (o_ntf_size_r),
    .i_ntf_rdy        (i_ntf_rdy),
    .o_coalesce_cnt_r (o_coalesce_cnt_r),
    .o_pend_cnt_r     (o_pend_cnt_r)
  );

  always #5 clk = ~clk;

  // Reference model: pending products as a FIFO of ids plus latest-value arrays.
  bit    m_vld;
  int    m_id, m_key, m_size, m_coal;
  int    m_q[$];
  bit    m_pend [16];
  int    m_tkey [16];
  int    m_tsize[16];
  int    dut_acc[$];

  task automatic model_reset();
    m_vld = 0; m_id = 0; m_key = 0; m_size = 0; m_coal = 0;
    m_q.delete();
    for (int i = 0; i < 16; i++) m_pend[i] = 0;
  endtask

  task automatic model_step(input logic v, input int id, input int k, input int s, input logic r);
    bit free, done;
    int h;
    free = !m_vld || r;
    done = 0;
    if (free && m_q.size() > 0) begin
      h = m_q.pop_front();
      m_pend[h] = 0;
      m_vld = 1;
      m_id  = h;
      if (v && id == h) begin
        m_key = k; m_size = s; done = 1;
        if (m_coal < 65535) m_coal++;
      end else begin
        m_key = m_tkey[h]; m_size = m_tsize[h];
      end
    end else if (free && v) begin
      m_vld = 1; m_id = id; m_key = k; m_size = s; done = 1;
    end else if (free) begin
      m_vld = 0;
    end
    if (v && !done) begin
      if (m_pend[id]) begin
        if (m_coal < 65535) m_coal++;
      end else begin
        m_pend[id] = 1;
        m_q.push_back(id);
      end
      m_tkey[id]  = k;
      m_tsize[id] = s;
    end
  endtask

  task automatic check_model();
    bit ok;
    n_chk++;
    ok = (o_ntf_vld_r == m_vld) && (int'(o_pend_cnt_r) == m_q.size()) && (int'(o_coalesce_cnt_r) == m_coal);
    if (m_vld)
      ok = ok && (int'(o_ntf_prod_id_r) == m_id) && (o_ntf_key_r == key_t'(m_key)) && (o_ntf_size_r == size_t'(m_size));
    if (ok) n_pass++;
    else $display("FAIL model_cmp t=%0t: vld %0b want %0b id %0d want %0d key %0d want %0d size %0d want %0d pend %0d want %0d coal %0d want %0d",
                  $time, o_ntf_vld_r, m_vld, o_ntf_prod_id_r, m_id, o_ntf_key_r, key_t'(m_key),
                  o_ntf_size_r, size_t'(m_size), o_pend_cnt_r, m_q.size(), o_coalesce_cnt_r, m_coal);
  endtask

  task automatic chk_eq(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // One clock: apply inputs, record any DUT beat accepted at the edge, step the model, compare.
  task automatic step(input logic v, input int id, input int k, input int s, input logic r);
    i_lv0_vld     = v;
    i_lv0_prod_id = id_t'(id);
    i_lv0_key     = key_t'(k);
    i_lv0_size    = size_t'(s);
    i_ntf_rdy     = r;
    if (o_ntf_vld_r && r) dut_acc.push_back(int'(o_ntf_prod_id_r));
    @(posedge clk);
    model_step(v, id, k, s, r);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    i_lv0_vld = 0;
    i_ntf_rdy = 0;
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  typedef struct {
    logic  vld; int id; int key; int size; logic rdy;
    logic  e_vld; int e_id; int e_key; int e_size; int e_pend; int e_coal;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 3, 100, 5, 1'b1,  1'b1, 3, 100, 5, 0, 0};
    vecs[1] = '{1'b0, 0,   0, 0, 1'b1,  1'b0, 0,   0, 0, 0, 0};
    vecs[2] = '{1'b1, 1,   7, 2, 1'b0,  1'b1, 1,   7, 2, 0, 0};
    vecs[3] = '{1'b1, 5,  10, 3, 1'b0,  1'b1, 1,   7, 2, 1, 0};
    vecs[4] = '{1'b1, 5,  11, 3, 1'b0,  1'b1, 1,   7, 2, 1, 1};
    vecs[5] = '{1'b1, 5,  12, 4, 1'b0,  1'b1, 1,   7, 2, 1, 2};
    vecs[6] = '{1'b0, 0,   0, 0, 1'b1,  1'b1, 5,  12, 4, 0, 2};
    vecs[7] = '{1'b0, 0,   0, 0, 1'b1,  1'b0, 0,   0, 0, 0, 2};

    model_reset();
    #2;
    chk_eq("reset_vld", o_ntf_vld_r, 0);
    chk_eq("reset_pend", o_pend_cnt_r, 0);
    chk_eq("reset_coal", o_coalesce_cnt_r, 0);
    chk_eq("reset_key", o_ntf_key_r, 0);
    do_reset();

    // Directed table: idle bypass, then coalescing behind a stalled egress.
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].vld, vecs[i].id, vecs[i].key, vecs[i].size, vecs[i].rdy);
      chk_eq($sformatf("vec%0d_vld", i), o_ntf_vld_r, vecs[i].e_vld);
      if (vecs[i].e_vld) begin
        chk_eq($sformatf("vec%0d_id", i), o_ntf_prod_id_r, vecs[i].e_id);
        chk_eq($sformatf("vec%0d_key", i), o_ntf_key_r, vecs[i].e_key);
        chk_eq($sformatf("vec%0d_size", i), o_ntf_size_r, vecs[i].e_size);
      end
      chk_eq($sformatf("vec%0d_pend", i), o_pend_cnt_r, vecs[i].e_pend);
      chk_eq($sformatf("vec%0d_coal", i), o_coalesce_cnt_r, vecs[i].e_coal);
    end

    // Order and pointer wrap: fill every product, drain, three rounds.
    do_reset();
    for (int rep = 0; rep < 3; rep++) begin
      for (int p = 0; p < 16; p++) step(1, p, $urandom, $urandom_range(0, 65535), 0);
      chk_eq($sformatf("wrap%0d_pend", rep), o_pend_cnt_r, 15);
      dut_acc.delete();
      for (int c = 0; c < 20; c++) step(0, 0, 0, 0, 1);
      chk_eq($sformatf("wrap%0d_n", rep), dut_acc.size(), 16);
      for (int p = 0; p < 16 && p < dut_acc.size(); p++)
        chk_eq($sformatf("wrap%0d_ord%0d", rep, p), dut_acc[p], p);
    end

    // Pop/ingress collision on the queue head.
    do_reset();
    step(1, 9, 1, 1, 0);
    step(1, 7, 20, 1, 0);
    chk_eq("coll_pend_before", o_pend_cnt_r, 1);
    step(1, 7, 21, 2, 1);
    chk_eq("coll_id", o_ntf_prod_id_r, 7);
    chk_eq("coll_key", o_ntf_key_r, 21);
    chk_eq("coll_size", o_ntf_size_r, 2);
    chk_eq("coll_coal", o_coalesce_cnt_r, 1);
    chk_eq("coll_pend_after", o_pend_cnt_r, 0);
    step(0, 0, 0, 0, 1);
    chk_eq("coll_no_dup", o_ntf_vld_r, 0);

    // Asynchronous reset with six ids pending.
    do_reset();
    for (int p = 0; p < 7; p++) step(1, p, 30 + p, p, 0);
    chk_eq("rstm_pend_before", o_pend_cnt_r, 6);
    #3;
    rst = 1;
    #1;
    chk_eq("rstm_vld", o_ntf_vld_r, 0);
    chk_eq("rstm_pend", o_pend_cnt_r, 0);
    chk_eq("rstm_id", o_ntf_prod_id_r, 0);
    chk_eq("rstm_key", o_ntf_key_r, 0);
    chk_eq("rstm_size", o_ntf_size_r, 0);
    model_reset();
    i_lv0_vld = 0;
    @(posedge clk);
    #1;
    rst = 0;
    step(1, 2, 50, 1, 1);
    chk_eq("rstm_byp_vld", o_ntf_vld_r, 1);
    chk_eq("rstm_byp_id", o_ntf_prod_id_r, 2);
    chk_eq("rstm_byp_key", o_ntf_key_r, 50);
    chk_eq("rstm_byp_pend", o_pend_cnt_r, 0);
    for (int c = 0; c < 4; c++) step(0, 0, 0, 0, 1);
    chk_eq("rstm_no_stale", o_ntf_vld_r, 0);

    // Random traffic with periodic long stalls, checked cycle by cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic v, r;
      int   id;
      v  = ($urandom_range(0, 3) != 0);
      id = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
      r  = ((c % 200) >= 190) ? 1'b0 : ($urandom_range(0, 9) < 6);
      step(v, id, $urandom, $urandom_range(0, 65535), r);
    end
    for (int c = 0; c < 40; c++) step(0, 0, 0, 0, 1);
    chk_eq("rand_drain_pend", o_pend_cnt_r, 0);
    chk_eq("rand_drain_vld", o_ntf_vld_r, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/v_notify_coalesce.md
Name: v_notify_coalesce

Overview:
- Sits directly downstream of the list update pipeline; consumes its level-0 notify bus (lv0_*), one update per cycle, no backpressure.
- Buffers and coalesces level-0 changes per product so a slow egress consumer (valid/ready) always gets the latest key/size per product.
- Emits products in first-pending order; capacity is one pending slot per product, so it cannot overflow.

Parameters:
- PROD_N, v_pkg::PRODUCTS_N (16): product count, equal to table depth and id-queue depth.
- CNT_W, 16: width of the saturating coalesce counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_lv0_vld  in  1  notify beat valid; no ready, always accepted
- i_lv0_prod_id  in  v_pkg::id_t  product id
- i_lv0_key  in  v_pkg::key_t  new level-0 key
- i_lv0_size  in  v_pkg::size_t  new level-0 size
- o_ntf_vld_r  out  1  egress valid (registered)
- o_ntf_prod_id_r  out  v_pkg::id_t  egress product
- o_ntf_key_r  out  v_pkg::key_t  egress key
- o_ntf_size_r  out  v_pkg::size_t  egress size
- i_ntf_rdy  in  1  egress ready
- o_coalesce_cnt_r  out  CNT_W  count of coalesced (overwritten) updates
- o_pend_cnt_r  out  $clog2(PROD_N)+1  number of queued ids

Behaviour:
- Reset (async, rst=1): every output is 0; pend[] is 0; queue rd/wr pointers and count are 0. Table key/size are not reset.
- Storage: pend[PROD_N], table key/size[PROD_N], and a circular id queue of depth PROD_N. Pointers wrap at PROD_N-1 to 0.
- Egress slot is free when o_ntf_vld_r=0 or (o_ntf_vld_r & i_ntf_rdy).
- Pop: when the slot is free and the queue is non-empty, pop head id h. Next cycle o_ntf_* = {h, table[h]}, o_ntf_vld_r=1. pend[h] clears.
- Idle bypass: when the slot is free, the queue is empty and i_lv0_vld=1, load the input straight into the egress register. Latency is 1 cycle. pend is not set and nothing is enqueued.
- Ingress, id p not pending and not bypassed: write table[p], set pend[p], push p.
- Ingress, p already pending: overwrite table[p], no push. o_coalesce_cnt_r increments and saturates at all-ones.
- Same-cycle ingress to the id being popped (p==h): the pop forwards the input key/size into the egress register. pend[h] clears, no push, and the counter increments (old value is superseded).
- Ingress for the id currently held un-accepted in the egress register: treated as a new update. It enqueues if not pending, so both values are delivered in order.
- Egress stall (vld & !rdy): o_ntf_* hold stable.
- o_pend_cnt_r tracks queue occupancy: +1 on push, -1 on pop, unchanged when both occur. It never exceeds PROD_N by construction; add an assertion that a push never hits a full queue.
- Egress order is the order of first pending arrival. Updates from one product are never reordered.
- Reset asserted mid-operation discards all pending state immediately; egress valid drops asynchronously.

Decomposition:
- v_pkg additions:
  - PRODUCTS_N
  - ntf_t struct {id_t prod_id; key_t key; size_t size}
  - coalesce counter width constant.
- Sub-module v_notify_coalesce_idq: circular id FIFO (push/pop/empty/full/count), depth PROD_N, async active-high reset.
- The pend bits, table and egress register stay in the top.

Test Plan:
- Idle bypass: empty, rdy=1; lv0 {id=3,key=100,size=5} at cycle 0 -> o_ntf_vld_r=1 with {3,100,5} at cycle 1, pend_cnt=0.
- Coalesce: rdy=0, egress holding id 1; send id 5 key 10, then id 5 key 11, then id 5 key 12 -> pend_cnt=1, coalesce_cnt=2. After rdy=1, egress gives {1,...} then {5,12,...} exactly once.
- Order and wrap: rdy=0; send ids 0..15 once each (bypass fills the slot with id 0) -> pend_cnt=15. Release rdy -> egress ids 0..15 in order. Repeat 3 times to exercise pointer wrap.
- Pop/ingress collision: queue head id 7 (key 20); in the cycle it pops, input id 7 key 21 -> egress {7,21}, no second id 7 emitted, coalesce_cnt +1.
- Stall stability: o_ntf_vld_r=1, rdy=0 for 10 cycles with random ingress to other ids -> o_ntf_* constant; all ids drain afterwards with latest values.
- Reset mid-stream: rst pulse with 6 ids pending -> outputs 0 asynchronously. After release, lv0 {2,50,1} bypasses in 1 cycle; no stale ids appear.
